uart_rx: RTL and testbench

//  Serial receiver for the UART: consumes rxclk_en (16x-baud strobe from the baud

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encoding, default frame
// geometry and the parity mode used when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_OVERSAMPLE   = 16;
    localparam int DEF_SAMPLE_POINT = 8;

    // XOR of payload and parity bit that counts as a good frame (0 = even parity).
    localparam logic PARITY_EVEN = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad; resets to 1 so the
// receiver sees an idle line out of reset.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, with sticky rdy/overrun and a frame_err pulse.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
    parameter int SAMPLE_POINT = DEF_SAMPLE_POINT
) (
    input  logic                 clk_50m,
    input  logic                 rst,
    input  logic                 rxclk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [TICK_W-1:0] START_LAST = TICK_W'(SAMPLE_POINT - 1);
    localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e             state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  armed_q, armed_d;
    logic [DATA_BITS-1:0]  data_q;
    logic                  rdy_q, frame_err_q, overrun_q;
    logic                  stop_sample, frame_done, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_q, par_bit_d;
    logic                  parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk_i (clk_50m),
        .rst_i (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
`endif
        if (rxclk_en) begin
            case (state_q)
                // A start edge only counts after the line has been seen high.
                ST_IDLE: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == START_LAST) begin
                        tick_d = '0;
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_q == BIT_LAST) begin
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_d    = '0;
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_q == BIT_LAST) begin
                        par_bit_d = rx_s;
                        tick_d    = '0;
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
`endif
                // A low stop bit leaves the receiver disarmed so a break cannot retrigger.
                ST_STOP: begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = ST_IDLE;
                        armed_d = rx_s;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        stop_sample = rxclk_en && (state_q == ST_STOP) && (tick_q == BIT_LAST);
        frame_done  = stop_sample && rx_s;
        stop_bad    = stop_sample && !rx_s;
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            data_q       <= '0;
            rdy_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= stop_bad;
            if (frame_done) begin
                data_q    <= shift_q;
                rdy_q     <= 1'b1;
                overrun_q <= rdy_q && !rdy_clr;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= ((^shift_q) ^ par_bit_q) != PARITY_EVEN;
`endif
            end else if (rdy_clr && rdy_q) begin
                rdy_q     <= 1'b0;
                overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
        end
    end

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are serialised bit by bit,
// expected deliveries are queued, and a monitor compares each DUT delivery.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       rxclk_en;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    int ferr_exp = 0;
    bit auto_ack = 1'b1;
    bit ack_req = 1'b0;

    // Entry layout: {parity_err, overrun, data}
    logic [9:0] exp_q[$];

    uart_rx dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .rxclk_en  (rxclk_en),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .data      (data),
        .rdy       (rdy),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    // ---------------- clock / reset / strobe ----------------
    always #10 clk_50m = ~clk_50m;

    initial begin
        int n;
        n = 0;
        rxclk_en = 1'b0;
        forever begin
            @(posedge clk_50m);
            #1;
            n++;
            rxclk_en = (n % 4 == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic odd_ones(input logic [7:0] b);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += int'(b[i]);
        return logic'(cnt % 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_clks(BIT_CLKS);
    endtask

    // Serialises one frame LSB-first and records what the receiver should report.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic pbit,
                              input logic exp_ovr);
        logic exp_perr;
        exp_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        exp_perr = odd_ones(b) ^ pbit;
`endif
        if (stop_v) exp_q.push_back({exp_perr, exp_ovr, b});
        else ferr_exp++;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b1, odd_ones(b), 1'b0);
        drive_bit(1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic       prev_rdy;
        logic       prev_ovr;
        logic       prev_ferr;
        logic [7:0] prev_data;
        logic       perr_now;
        logic [9:0] act;
        logic [9:0] exp;
        prev_rdy  = 1'b0;
        prev_ovr  = 1'b0;
        prev_ferr = 1'b0;
        prev_data = 8'h00;
        rdy_clr   = 1'b0;
        forever begin
            @(negedge clk_50m);
            rdy_clr = 1'b0;
            perr_now = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_now = parity_err;
`endif
            if (!rst) begin
                act = {perr_now, overrun, data};
                if (rdy && (!prev_rdy || data !== prev_data || (overrun && !prev_ovr))) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_delivery: got 0x%0h expected no delivery", act);
                    end else begin
                        exp = exp_q.pop_front();
                        check("delivery", 32'(act), 32'(exp));
                    end
                    if (auto_ack) rdy_clr = 1'b1;
                end
                if (ack_req && rdy) begin
                    rdy_clr = 1'b1;
                    ack_req = 1'b0;
                end
                if (frame_err && prev_ferr) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_err_width: got 2+ cycles expected 1");
                end
                if (frame_err && !prev_ferr) ferr_seen++;
            end
            prev_rdy  = rdy;
            prev_ovr  = overrun;
            prev_ferr = frame_err;
            prev_data = data;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        logic [7:0] b;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(5);
        check("reset_rdy", 32'(rdy), 32'(0));
        check("reset_data", 32'(data), 32'(0));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        check("reset_overrun", 32'(overrun), 32'(0));
        rst = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Single clean frame
        send_good(8'hA5);
        check("t1_data", 32'(data), 32'(8'hA5));

        // Two frames without acknowledge -> overrun, then clear
        auto_ack = 1'b0;
        send_frame(8'h3C, 1'b1, odd_ones(8'h3C), 1'b0);
        drive_bit(1'b1);
        send_frame(8'hC3, 1'b1, odd_ones(8'hC3), 1'b1);
        drive_bit(1'b1);
        check("t2_data", 32'(data), 32'(8'hC3));
        check("t2_rdy", 32'(rdy), 32'(1));
        check("t2_overrun", 32'(overrun), 32'(1));
        ack_req = 1'b1;
        wait_clks(4);
        check("t2_rdy_cleared", 32'(rdy), 32'(0));
        check("t2_overrun_cleared", 32'(overrun), 32'(0));
        auto_ack = 1'b1;

        // Bad stop bit followed by a break: one frame_err, no re-trigger
        send_frame(8'h55, 1'b0, odd_ones(8'h55), 1'b0);
        rx = 1'b0;
        wait_clks(3 * BIT_CLKS);
        check("t3_frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
        check("t3_rdy", 32'(rdy), 32'(0));
        check("t3_data_kept", 32'(data), 32'(8'hC3));
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_good(8'h5A);

        // Short low glitch -> false start
        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("t4_rdy", 32'(rdy), 32'(0));
        check("t4_frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
        send_good(8'h96);

        // Reset in the middle of the data bits of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        check("t5_rdy_after_rst", 32'(rdy), 32'(0));
        check("t5_data_after_rst", 32'(data), 32'(0));
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_good(8'h01);
        check("t5_data", 32'(data), 32'(8'h01));

`ifdef UART_RX_PARITY_EN
        // Wrong parity still delivers the byte with parity_err set
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1);
        check("t6_data", 32'(data), 32'(8'h07));
        check("t6_parity_err_cleared", 32'(parity_err), 32'(0));
`endif

        // Randomized clean frames with random inter-frame gaps
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom_range(0, 255));
`ifdef UART_RX_PARITY_EN
            send_frame(b, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
`else
            send_frame(b, 1'b1, 1'b0, 1'b0);
`endif
            wait_clks($urandom_range(1, 100));
        end
        drive_bit(1'b1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            wait_clks(1);
            guard++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        check("frame_err_total", 32'(ferr_seen), 32'(ferr_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
